// File: rtl/sme_param.sv
// sme_param: parametrised string-match engine.
// Loads a string and a pattern byte-serially, then scans one candidate
// position per clock and reports the first match index and the match count.
// Supports '^' / '$' word anchors, '.' wildcard and optional case folding.
module sme_param #(
   parameter int W       = 8,
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 9,
   parameter int NOCASE  = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [W-1:0]                 chardata,
   input  logic                         isstring,
   input  logic                         ispattern,
   output logic                         valid,
   output logic                         match,
   output logic [$clog2(STR_MAX)-1:0]   match_index,
   output logic [$clog2(STR_MAX+1)-1:0] match_count
);

   localparam int IW  = $clog2(STR_MAX) + 1;
   localparam int LW  = $clog2(PAT_MAX + 1);
   localparam int SLW = $clog2(STR_MAX + 1);
   localparam int MIW = $clog2(STR_MAX);
   localparam int SIW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
   localparam int PIW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
   // common arithmetic width, wide enough for i + L without wrap
   localparam int SW  = ((IW > LW) ? IW : LW) + 1;

   localparam logic [W-1:0] CH_CARET  = W'(8'h5E);
   localparam logic [W-1:0] CH_DOLLAR = W'(8'h24);
   localparam logic [W-1:0] CH_DOT    = W'(8'h2E);
   localparam logic [W-1:0] CH_SPACE  = W'(8'h20);

   typedef enum logic [0:0] {ST_LOAD = 1'b0, ST_SEARCH = 1'b1} state_t;

   state_t          state_r, state_nx_s;
   logic [W-1:0]    str_r [0:STR_MAX-1];
   logic [W-1:0]    pat_r [0:PAT_MAX-1];
   logic [SLW-1:0]  ws_r;
   logic [LW-1:0]   wp_r;
   logic            str_seen_r, pat_seen_r;
   logic [SW-1:0]   slen_r, blen_r, nsrch_r, i_r, cnt_r, first_r;
   logic            a_r, z_r;
   logic            start_s, last_s;
   logic            a_dec_s, z_dec_s;
   logic [SW-1:0]   pl_s, sl_s, l_dec_s, n_dec_s;
   logic [SW-1:0]   sidx_s, pidx_s, end_s;
   logic [W-1:0]    sc_s, pc_s;
   logic            body_ok_s, a_ok_s, z_ok_s, hit_s;
   logic [SW-1:0]   cnt_nx_s, first_nx_s;

   // Lower-case a letter when case folding is enabled; other codes pass through.
   function automatic logic [W-1:0] fold_char(input logic [W-1:0] c);
      logic [W-1:0] r;
      r = c;
      if ((NOCASE != 0) && (c[7:0] >= 8'h41) && (c[7:0] <= 8'h5A)) begin
         r[5] = 1'b1;
      end else begin
         r = c;
      end
      return r;
   endfunction

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= ST_LOAD;
      else       state_r <= state_nx_s;
   end

   // Next-state logic: LOAD -> SEARCH on the load-complete cycle, back after the last position.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_LOAD:   state_nx_s = start_s ? ST_SEARCH : ST_LOAD;
         ST_SEARCH: state_nx_s = last_s ? ST_LOAD : ST_SEARCH;
         default:   state_nx_s = ST_LOAD;
      endcase
   end

   // Control decode: search start (first idle cycle after a pattern) and final scan edge.
   always_comb begin
      start_s = 1'b0;
      last_s  = 1'b0;
      case (state_r)
         ST_LOAD:   start_s = !isstring && !ispattern && pat_seen_r;
         ST_SEARCH: last_s  = ((i_r + SW'(1)) >= nsrch_r);
         default: begin
            start_s = 1'b0;
            last_s  = 1'b0;
         end
      endcase
   end

   // Load datapath: first char of each kind in a phase restarts its write pointer; overflow is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int n = 0; n < STR_MAX; n++) str_r[n] <= '0;
         for (int n = 0; n < PAT_MAX; n++) pat_r[n] <= '0;
         ws_r       <= '0;
         wp_r       <= '0;
         str_seen_r <= 1'b0;
         pat_seen_r <= 1'b0;
      end else if (last_s) begin
         str_seen_r <= 1'b0;
         pat_seen_r <= 1'b0;
      end else if (state_r == ST_LOAD) begin
         if (isstring) begin
            if (!str_seen_r) begin
               str_r[0]   <= chardata;
               ws_r       <= SLW'(1);
               str_seen_r <= 1'b1;
            end else if (ws_r < SLW'(STR_MAX)) begin
               str_r[SIW'(ws_r)] <= chardata;
               ws_r              <= ws_r + SLW'(1);
            end
         end else if (ispattern) begin
            if (!pat_seen_r) begin
               pat_r[0]   <= chardata;
               wp_r       <= LW'(1);
               pat_seen_r <= 1'b1;
            end else if (wp_r < LW'(PAT_MAX)) begin
               pat_r[PIW'(wp_r)] <= chardata;
               wp_r              <= wp_r + LW'(1);
            end
         end
      end
   end

   // Pattern decode at search start: anchors, body length and number of candidate positions.
   always_comb begin
      pl_s    = SW'(wp_r);
      sl_s    = SW'(ws_r);
      a_dec_s = (pat_r[0] == CH_CARET);
      z_dec_s = (wp_r != '0) && (pat_r[PIW'(pl_s - SW'(1))] == CH_DOLLAR) && (pl_s > SW'(a_dec_s));
      l_dec_s = pl_s - SW'(a_dec_s) - SW'(z_dec_s);
      if ((l_dec_s == '0) || (l_dec_s > sl_s)) n_dec_s = '0;
      else                                     n_dec_s = sl_s - l_dec_s + SW'(1);
   end

   // Candidate evaluation: all body chars of position i compared in parallel, plus anchor context.
   always_comb begin
      body_ok_s = 1'b1;
      sidx_s    = '0;
      pidx_s    = '0;
      sc_s      = '0;
      pc_s      = '0;
      for (int k = 0; k < PAT_MAX; k++) begin
         sidx_s    = i_r + SW'(k);
         pidx_s    = SW'(k) + SW'(a_r);
         sc_s      = (sidx_s < SW'(STR_MAX)) ? str_r[SIW'(sidx_s)] : '0;
         pc_s      = (pidx_s < SW'(PAT_MAX)) ? pat_r[PIW'(pidx_s)] : '0;
         body_ok_s = body_ok_s & ((SW'(k) >= blen_r) | (pc_s == CH_DOT) |
                                  (fold_char(pc_s) == fold_char(sc_s)));
      end
      end_s  = i_r + blen_r;
      a_ok_s = !a_r || (i_r == '0) ||
               (((i_r - SW'(1)) < SW'(STR_MAX)) && (str_r[SIW'(i_r - SW'(1))] == CH_SPACE));
      z_ok_s = !z_r || (end_s == slen_r) ||
               ((end_s < SW'(STR_MAX)) && (str_r[SIW'(end_s)] == CH_SPACE));
      hit_s  = (state_r == ST_SEARCH) && (i_r < nsrch_r) && (end_s <= slen_r) &&
               body_ok_s && a_ok_s && z_ok_s;
      cnt_nx_s   = cnt_r + SW'(hit_s);
      first_nx_s = (hit_s && (cnt_r == '0)) ? i_r : first_r;
   end

   // Search datapath: latch job parameters at start, then step one position per clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slen_r  <= '0;
         blen_r  <= '0;
         nsrch_r <= '0;
         a_r     <= 1'b0;
         z_r     <= 1'b0;
         i_r     <= '0;
         cnt_r   <= '0;
         first_r <= '0;
      end else if (start_s) begin
         slen_r  <= sl_s;
         blen_r  <= l_dec_s;
         nsrch_r <= n_dec_s;
         a_r     <= a_dec_s;
         z_r     <= z_dec_s;
         i_r     <= '0;
         cnt_r   <= '0;
         first_r <= '0;
      end else if (state_r == ST_SEARCH) begin
         i_r     <= i_r + SW'(1);
         cnt_r   <= cnt_nx_s;
         first_r <= first_nx_s;
      end
   end

   // Result registers: one-cycle valid strobe, result fields held until the next job completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid       <= 1'b0;
         match       <= 1'b0;
         match_index <= '0;
         match_count <= '0;
      end else begin
         valid <= last_s;
         if (last_s) begin
            match       <= (cnt_nx_s != '0);
            match_index <= MIW'(first_nx_s);
            match_count <= SLW'(cnt_nx_s);
         end
      end
   end

endmodule

// File: tb/tb_sme_param.sv
// Testbench for sme_param: two instances (case-sensitive PAT_MAX=9 and
// case-folding PAT_MAX=34) share stimulus; results are compared with a
// string-level reference model.
module tb_sme_param;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] chardata;
   logic       isstring, ispattern;
   logic       valid0, match0, valid1, match1;
   logic [4:0] mi0, mi1;
   logic [5:0] mc0, mc1;

   always #5 clk = ~clk;

   sme_param #(.W(8), .STR_MAX(32), .PAT_MAX(9), .NOCASE(0)) dut0 (
      .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
      .valid(valid0), .match(match0), .match_index(mi0), .match_count(mc0));

   sme_param #(.W(8), .STR_MAX(32), .PAT_MAX(34), .NOCASE(1)) dut1 (
      .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
      .valid(valid1), .match(match1), .match_index(mi1), .match_count(mc1));

   int    checks = 0;
   int    errors = 0;
   string ref_str = "";
   int    patmax [2] = '{9, 34};
   bit    nocase [2] = '{1'b0, 1'b1};
   int    got_lat[2], got_idx[2], got_cnt[2];
   bit    got_m  [2];

   function automatic byte fold_c(input byte c, input bit nc);
      if (nc && c >= 8'h41 && c <= 8'h5A) return byte'(c + 8'd32);
      return c;
   endfunction

   // Reference: scan every start position of the string directly.
   function automatic void ref_model(input string s, input string p, input bit nc,
                                     output int n, output int cnt, output int first);
      int  a, z, l, slen;
      bit  ok;
      byte bc;
      slen = s.len();
      a = (p.len() > 0 && p[0] == 8'h5E) ? 1 : 0;
      z = (p.len() > a && p[p.len()-1] == 8'h24) ? 1 : 0;
      l = p.len() - a - z;
      n = (l == 0 || l > slen) ? 0 : slen - l + 1;
      cnt = 0;
      first = 0;
      for (int i = 0; i < n; i++) begin
         ok = 1'b1;
         for (int k = 0; k < l; k++) begin
            bc = p[a+k];
            if (bc != 8'h2E && fold_c(bc, nc) != fold_c(s[i+k], nc)) ok = 1'b0;
         end
         if (a == 1 && i != 0) begin
            if (s[i-1] != 8'h20) ok = 1'b0;
         end
         if (z == 1 && i + l != slen) begin
            if (s[i+l] != 8'h20) ok = 1'b0;
         end
         if (ok) begin
            if (cnt == 0) first = i;
            cnt++;
         end
      end
   endfunction

   task automatic cyc;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Load (optionally) a string and a pattern, then wait for both result strobes.
   task automatic run_job(input string s, input bit send, input string p);
      if (send) begin
         for (int i = 0; i < s.len(); i++) begin
            isstring = 1'b1;
            chardata = s[i];
            cyc();
         end
         isstring = 1'b0;
         ref_str = (s.len() > 32) ? s.substr(0, 31) : s;
      end
      for (int i = 0; i < p.len(); i++) begin
         ispattern = 1'b1;
         chardata  = p[i];
         cyc();
      end
      ispattern = 1'b0;
      chardata  = 8'h00;
      cyc();
      got_lat = '{-1, -1};
      for (int e = 1; e <= 80 && (got_lat[0] < 0 || got_lat[1] < 0); e++) begin
         cyc();
         if (valid0 && got_lat[0] < 0) begin
            got_lat[0] = e; got_m[0] = match0; got_idx[0] = int'(mi0); got_cnt[0] = int'(mc0);
         end
         if (valid1 && got_lat[1] < 0) begin
            got_lat[1] = e; got_m[1] = match1; got_idx[1] = int'(mi1); got_cnt[1] = int'(mc1);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; isstring = 1'b0; ispattern = 1'b0; chardata = 8'h00;
      cyc(); cyc();
      checks++; if ({valid0, match0, mi0, mc0} !== 13'd0) begin
         errors++; $display("FAIL reset dut0: got v=%b m=%b i=%0d c=%0d, expected all 0", valid0, match0, mi0, mc0);
      end
      checks++; if ({valid1, match1, mi1, mc1} !== 13'd0) begin
         errors++; $display("FAIL reset dut1: got v=%b m=%b i=%0d c=%0d, expected all 0", valid1, match1, mi1, mc1);
      end
      reset = 1'b0;
      cyc();
      checks++; if ({valid0, valid1} !== 2'b00) begin
         errors++; $display("FAIL reset_idle: got valid %b%b, expected 00", valid0, valid1);
      end
   endtask

   task automatic test_directed;
      string t_s [8] = '{"hello world", "", "", "ab ab", "", "", "Foo fOO",
                         "abcdefghijabcdefghijabcdefghijabcdefghij"};
      bit    t_snd[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      string t_p [8] = '{"o", "^wor", "^orl", "b$", "a.$", "^$", "foo",
                         "abcdefghijabcdefghijabcdefghijabc"};
      for (int j = 0; j < 8; j++) begin
         run_job(t_s[j], t_snd[j], t_p[j]);
         for (int d = 0; d < 2; d++) begin
            string pd;
            int n, c, f, el;
            pd = (t_p[j].len() > patmax[d]) ? t_p[j].substr(0, patmax[d]-1) : t_p[j];
            ref_model(ref_str, pd, nocase[d], n, c, f);
            el = (n > 1) ? n : 1;
            checks++; if (got_lat[d] !== el) begin
               errors++; $display("FAIL dir%0d dut%0d latency: got %0d expected %0d", j, d, got_lat[d], el);
            end
            checks++; if (got_m[d] !== (c > 0)) begin
               errors++; $display("FAIL dir%0d dut%0d match: got %0d expected %0d", j, d, got_m[d], c > 0);
            end
            checks++; if (got_idx[d] !== f) begin
               errors++; $display("FAIL dir%0d dut%0d index: got %0d expected %0d", j, d, got_idx[d], f);
            end
            checks++; if (got_cnt[d] !== c) begin
               errors++; $display("FAIL dir%0d dut%0d count: got %0d expected %0d", j, d, got_cnt[d], c);
            end
         end
      end
   endtask

   task automatic test_random;
      string sa = "aAb .";
      string pa = "aAb. ";
      for (int j = 0; j < 30; j++) begin
         string s, p;
         bit    send;
         int    sl, pl;
         s = ""; p = "";
         send = ($urandom_range(2) != 0) || (j == 0);
         sl = $urandom_range(40, 1);
         for (int i = 0; i < sl; i++) s = $sformatf("%s%c", s, sa[$urandom_range(4)]);
         if ($urandom_range(3) == 0) p = "^";
         pl = $urandom_range(11, 1);
         for (int i = 0; i < pl; i++) p = $sformatf("%s%c", p, pa[$urandom_range(4)]);
         if ($urandom_range(3) == 0) p = {p, "$"};
         run_job(s, send, p);
         for (int d = 0; d < 2; d++) begin
            string pd;
            int n, c, f, el;
            pd = (p.len() > patmax[d]) ? p.substr(0, patmax[d]-1) : p;
            ref_model(ref_str, pd, nocase[d], n, c, f);
            el = (n > 1) ? n : 1;
            checks++; if (got_lat[d] !== el) begin
               errors++; $display("FAIL rand%0d dut%0d latency: got %0d expected %0d", j, d, got_lat[d], el);
            end
            checks++; if (got_m[d] !== (c > 0)) begin
               errors++; $display("FAIL rand%0d dut%0d match: got %0d expected %0d", j, d, got_m[d], c > 0);
            end
            checks++; if (got_idx[d] !== f) begin
               errors++; $display("FAIL rand%0d dut%0d index: got %0d expected %0d", j, d, got_idx[d], f);
            end
            checks++; if (got_cnt[d] !== c) begin
               errors++; $display("FAIL rand%0d dut%0d count: got %0d expected %0d", j, d, got_cnt[d], c);
            end
         end
      end
   endtask

   task automatic test_reset_midscan;
      string s20 = "abcdefghijklmnopqrst";
      int    seen;
      run_job("abcabc", 1'b1, "c");   // leave non-zero results behind
      for (int i = 0; i < s20.len(); i++) begin
         isstring = 1'b1; chardata = s20[i]; cyc();
      end
      isstring = 1'b0;
      ispattern = 1'b1; chardata = 8'h61; cyc();
      ispattern = 1'b0; chardata = 8'h00;
      cyc();          // E0
      cyc(); cyc();   // E1, E2
      reset = 1'b1;   // asserted into E3
      #1;
      checks++; if ({valid0, match0, mi0, mc0, valid1, match1, mi1, mc1} !== 26'd0) begin
         errors++; $display("FAIL midscan_reset: got v=%b%b m=%b%b i=%0d/%0d c=%0d/%0d, expected all 0",
                            valid0, valid1, match0, match1, mi0, mi1, mc0, mc1);
      end
      cyc();
      reset = 1'b0;
      ref_str = "";
      seen = 0;
      for (int e = 0; e < 30; e++) begin
         cyc();
         if (valid0 || valid1) seen++;
      end
      checks++; if (seen !== 0) begin
         errors++; $display("FAIL midscan_novalid: got %0d valid cycles, expected 0", seen);
      end
      run_job("aa", 1'b1, "a");
      for (int d = 0; d < 2; d++) begin
         checks++; if (got_lat[d] !== 2 || got_m[d] !== 1'b1) begin
            errors++; $display("FAIL reload dut%0d: got latency %0d match %0d, expected 2 1", d, got_lat[d], got_m[d]);
         end
         checks++; if (got_idx[d] !== 0 || got_cnt[d] !== 2) begin
            errors++; $display("FAIL reload dut%0d: got index %0d count %0d, expected 0 2", d, got_idx[d], got_cnt[d]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_midscan();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
